// File: rtl/coherent_averager_if.sv
// Sample-in / sum-out stream bundle for coherent_averager.
interface coherent_averager_if #(
    parameter int DATA_W = 32,
    parameter int ACC_W  = 48
);
    logic              data_valid;
    logic [DATA_W-1:0] data;
    logic              result_valid;
    logic [ACC_W-1:0]  result;
    logic [15:0]       result_index;

    modport master (
        output data_valid,
        output data,
        input  result_valid,
        input  result,
        input  result_index
    );

    modport slave (
        input  data_valid,
        input  data,
        output result_valid,
        output result,
        output result_index
    );
endinterface

// File: rtl/coherent_averager.sv
// Streaming coherent averager: accumulates N periods of P points in a RAM and emits per-point sums.
// Optional signed-overflow detection is built when COHERENT_AVG_OVERFLOW_EN is defined.
module coherent_averager #(
    parameter int DATA_W = 32,
    parameter int ACC_W  = 48,
    parameter int ADDR_W = 10
) (
    input  logic                clock,
    input  logic                reset_n,
    input  logic                enable,
    input  logic [15:0]         ptos_x_ciclo,
    input  logic [15:0]         ciclos,
    coherent_averager_if.slave  bus,
    output logic                done,
    output logic                config_error,
    output logic                overflow
);

    localparam logic [16:0] MAX_PTS = 17'(2 ** ADDR_W);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

`ifdef COHERENT_AVG_OVERFLOW_EN
    function automatic logic add_ovf(input logic [ACC_W-1:0] a,
                                     input logic [ACC_W-1:0] b,
                                     input logic [ACC_W-1:0] s);
        return (a[ACC_W-1] == b[ACC_W-1]) && (s[ACC_W-1] != a[ACC_W-1]);
    endfunction
`endif

    state_t             r_state;
    logic [15:0]        r_pts;
    logic [15:0]        r_last_cyc;
    logic [15:0]        r_idx;
    logic [15:0]        r_cyc;
    logic               r_all_in;
    logic               r_s1_valid;
    logic               r_s1_first;
    logic               r_s1_last;
    logic [15:0]        r_s1_idx;
    logic [DATA_W-1:0]  r_s1_data;
    logic [ACC_W-1:0]   r_rd_data;
    logic               r_result_valid;
    logic [ACC_W-1:0]   r_result;
    logic [15:0]        r_result_index;
    logic               r_done;
    logic               r_config_error;
    logic               r_overflow;
    logic [ACC_W-1:0]   r_mem [0:(2**ADDR_W)-1];

    logic               w_range_ok;
    logic               w_accept;
    logic               w_idx_wrap;
    logic               w_cyc_last;
    logic [ACC_W-1:0]   w_opa;
    logic [ACC_W-1:0]   w_opb;
    logic [ACC_W-1:0]   w_sum;
    logic               w_ovf;
    logic               w_final;

    assign w_range_ok = ({1'b0, ptos_x_ciclo} >= 17'd2) && ({1'b0, ptos_x_ciclo} <= MAX_PTS);
    // Once the last sample of the last period is in, later strobes are ignored
    assign w_accept   = enable && (r_state == ST_ACCUM) && bus.data_valid && !r_all_in;
    assign w_idx_wrap = (r_idx == (r_pts - 16'd1));
    assign w_cyc_last = (r_cyc == r_last_cyc);

    // Period 0 never reads the RAM, so stale contents need no clearing pass
    assign w_opa   = r_s1_first ? {ACC_W{1'b0}} : r_rd_data;
    assign w_opb   = ACC_W'($signed(r_s1_data));
    assign w_sum   = w_opa + w_opb;
    assign w_final = r_s1_valid && r_s1_last && (r_s1_idx == (r_pts - 16'd1));

`ifdef COHERENT_AVG_OVERFLOW_EN
    assign w_ovf = add_ovf(w_opa, w_opb, w_sum);
`else
    assign w_ovf = 1'b0;
`endif

    // Point memory: read at acceptance, written back from stage 2 for non-final periods
    always_ff @(posedge clock) begin
        if (w_accept) begin
            r_rd_data <= r_mem[r_idx[ADDR_W-1:0]];
        end
        if (enable && r_s1_valid && !r_s1_last) begin
            r_mem[r_s1_idx[ADDR_W-1:0]] <= w_sum;
        end
    end

    // Control FSM, counters, stage-1 pipeline registers and registered outputs
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state        <= ST_IDLE;
            r_pts          <= 16'd0;
            r_last_cyc     <= 16'd0;
            r_idx          <= 16'd0;
            r_cyc          <= 16'd0;
            r_all_in       <= 1'b0;
            r_s1_valid     <= 1'b0;
            r_s1_first     <= 1'b0;
            r_s1_last      <= 1'b0;
            r_s1_idx       <= 16'd0;
            r_s1_data      <= {DATA_W{1'b0}};
            r_result_valid <= 1'b0;
            r_result       <= {ACC_W{1'b0}};
            r_result_index <= 16'd0;
            r_done         <= 1'b0;
            r_config_error <= 1'b0;
            r_overflow     <= 1'b0;
        end else begin
            r_result_valid <= 1'b0;
            if (!enable) begin
                r_state    <= ST_IDLE;
                r_s1_valid <= 1'b0;
                r_done     <= 1'b0;
                r_idx      <= 16'd0;
                r_cyc      <= 16'd0;
                r_all_in   <= 1'b0;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        r_s1_valid <= 1'b0;
                        if (w_range_ok) begin
                            r_state        <= ST_ACCUM;
                            r_pts          <= ptos_x_ciclo;
                            r_last_cyc     <= (ciclos == 16'd0) ? 16'd0 : (ciclos - 16'd1);
                            r_idx          <= 16'd0;
                            r_cyc          <= 16'd0;
                            r_all_in       <= 1'b0;
                            r_done         <= 1'b0;
                            r_config_error <= 1'b0;
                            r_overflow     <= 1'b0;
                        end else begin
                            r_config_error <= 1'b1;
                        end
                    end
                    ST_ACCUM: begin
                        r_s1_valid <= w_accept;
                        if (w_accept) begin
                            r_s1_idx   <= r_idx;
                            r_s1_data  <= bus.data;
                            r_s1_first <= (r_cyc == 16'd0);
                            r_s1_last  <= w_cyc_last;
                            if (w_idx_wrap) begin
                                r_idx <= 16'd0;
                                r_cyc <= r_cyc + 16'd1;
                                if (w_cyc_last) begin
                                    r_all_in <= 1'b1;
                                end
                            end else begin
                                r_idx <= r_idx + 16'd1;
                            end
                        end
                        if (r_s1_valid) begin
                            if (w_ovf) begin
                                r_overflow <= 1'b1;
                            end
                            if (r_s1_last) begin
                                r_result_valid <= 1'b1;
                                r_result       <= w_sum;
                                r_result_index <= r_s1_idx;
                            end
                        end
                        if (w_final) begin
                            r_done  <= 1'b1;
                            r_state <= ST_DONE;
                        end
                    end
                    ST_DONE: begin
                        r_s1_valid <= 1'b0;
                    end
                    default: begin
                        r_state    <= ST_IDLE;
                        r_s1_valid <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign bus.result_valid = r_result_valid;
    assign bus.result       = r_result;
    assign bus.result_index = r_result_index;
    assign done             = r_done;
    assign config_error     = r_config_error;
    assign overflow         = r_overflow;

endmodule

// File: tb/tb_coherent_averager.sv
// Directed bench for coherent_averager: table of accumulation runs plus abort, config and overflow sequences.
module tb_coherent_averager;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset_n;
    logic        enable;
    logic [15:0] ptos;
    logic [15:0] ciclos;
    logic        done;
    logic        config_error;
    logic        overflow;

    logic        o_enable;
    logic [15:0] o_ptos;
    logic [15:0] o_ciclos;
    logic        o_done;
    logic        o_cfg;
    logic        o_ovf;

    coherent_averager_if #(.DATA_W(32), .ACC_W(48)) bus ();
    coherent_averager_if #(.DATA_W(32), .ACC_W(32)) obus ();

    coherent_averager #(.DATA_W(32), .ACC_W(48), .ADDR_W(10)) dut (
        .clock        (clk),
        .reset_n      (reset_n),
        .enable       (enable),
        .ptos_x_ciclo (ptos),
        .ciclos       (ciclos),
        .bus          (bus.slave),
        .done         (done),
        .config_error (config_error),
        .overflow     (overflow)
    );

    coherent_averager #(.DATA_W(32), .ACC_W(32), .ADDR_W(4)) dut_ovf (
        .clock        (clk),
        .reset_n      (reset_n),
        .enable       (o_enable),
        .ptos_x_ciclo (o_ptos),
        .ciclos       (o_ciclos),
        .bus          (obus.slave),
        .done         (o_done),
        .config_error (o_cfg),
        .overflow     (o_ovf)
    );

    typedef struct packed {
        int p;
        int n;
        int gap;
        int base;
        int step;
        logic [0:7][31:0] exp;
    } vec_t;

    typedef struct {
        int     at;
        int     idx;
        longint val;
        bit     last;
    } exp_t;

    vec_t   tab [6];
    exp_t   expq [$];
    exp_t   e;
    int     total = 0;
    int     bad   = 0;
    int     cyc   = 0;

`ifdef COHERENT_AVG_OVERFLOW_EN
    localparam longint OVF_EXP = 1;
`else
    localparam longint OVF_EXP = 0;
`endif

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input longint act, input longint req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Scoreboard for the main instance: every result must match the next queued expectation
    always @(negedge clk) begin
        if (reset_n && bus.result_valid) begin
            if (expq.size() == 0) begin
                check("unexpected_result", 1, 0);
            end else begin
                e = expq.pop_front();
                check("result_value", $signed(bus.result), e.val);
                check("result_index", bus.result_index, e.idx);
                check("result_latency", cyc, e.at);
                check("done_with_result", done, e.last);
            end
        end
    end

    task automatic run_vec(input vec_t v);
        int neff;
        int j;
        int t;
        neff = (v.n == 0) ? 1 : v.n;
        @(negedge clk);
        ptos = 16'(v.p);
        ciclos = 16'(v.n);
        enable = 1'b1;
        bus.data_valid = 1'b1;
        bus.data = 32'd999;
        @(negedge clk);
        check("cfg_clear_on_start", config_error, 0);
        for (int k = 0; k < v.p * neff; k++) begin
            j = k % v.p;
            bus.data_valid = 1'b1;
            bus.data = 32'(v.base + v.step * j);
            if (k >= v.p * (neff - 1))
                expq.push_back('{cyc + 2, j, longint'(int'(v.exp[j])), (k == v.p * neff - 1)});
            @(negedge clk);
            for (int g = 0; g < v.gap; g++) begin
                bus.data_valid = 1'b0;
                @(negedge clk);
            end
        end
        bus.data_valid = 1'b1;
        bus.data = 32'd12345;
        t = 0;
        while (!done && t < 40) begin
            @(negedge clk);
            t++;
        end
        check("done_set", done, 1);
        repeat (3) @(negedge clk);
        check("queue_drained", expq.size(), 0);
        check("valid_low_after", bus.result_valid, 0);
        check("hold_result", $signed(bus.result), longint'(int'(v.exp[v.p - 1])));
        check("hold_index", bus.result_index, v.p - 1);
        check("done_held", done, 1);
        enable = 1'b0;
        bus.data_valid = 1'b0;
        expq.delete();
        @(negedge clk);
        check("done_clear", done, 0);
    endtask

    initial begin
        vec_t abort_v;
        tab[0] = '{p:4, n:3, gap:0, base:10, step:10,
                   exp:{32'sd30, 32'sd60, 32'sd90, 32'sd120, 32'sd0, 32'sd0, 32'sd0, 32'sd0}};
        tab[1] = '{p:2, n:1, gap:0, base:-5, step:12,
                   exp:{-32'sd5, 32'sd7, 32'sd0, 32'sd0, 32'sd0, 32'sd0, 32'sd0, 32'sd0}};
        tab[2] = '{p:8, n:2, gap:2, base:0, step:1,
                   exp:{32'sd0, 32'sd2, 32'sd4, 32'sd6, 32'sd8, 32'sd10, 32'sd12, 32'sd14}};
        tab[3] = '{p:3, n:0, gap:1, base:100, step:-50,
                   exp:{32'sd100, 32'sd50, 32'sd0, 32'sd0, 32'sd0, 32'sd0, 32'sd0, 32'sd0}};
        tab[4] = '{p:2, n:4, gap:0, base:-1000000, step:3000000,
                   exp:{-32'sd4000000, 32'sd8000000, 32'sd0, 32'sd0, 32'sd0, 32'sd0, 32'sd0, 32'sd0}};
        tab[5] = '{p:5, n:2, gap:1, base:-3, step:2,
                   exp:{-32'sd6, -32'sd2, 32'sd2, 32'sd6, 32'sd10, 32'sd0, 32'sd0, 32'sd0}};
        abort_v = '{p:4, n:2, gap:0, base:1, step:0,
                    exp:{32'sd2, 32'sd2, 32'sd2, 32'sd2, 32'sd0, 32'sd0, 32'sd0, 32'sd0}};

        reset_n = 1'b0;
        enable = 1'b0; ptos = 16'd0; ciclos = 16'd0;
        bus.data_valid = 1'b0; bus.data = 32'd0;
        o_enable = 1'b0; o_ptos = 16'd0; o_ciclos = 16'd0;
        obus.data_valid = 1'b0; obus.data = 32'd0;
        repeat (3) @(negedge clk);
        check("rst_result_valid", bus.result_valid, 0);
        check("rst_result", bus.result, 0);
        check("rst_index", bus.result_index, 0);
        check("rst_done", done, 0);
        check("rst_cfg", config_error, 0);
        check("rst_ovf", overflow, 0);
        reset_n = 1'b1;
        @(negedge clk);

        // Range boundaries: 1024 starts, 1 and 1025 are rejected
        ptos = 16'd1024; ciclos = 16'd1; enable = 1'b1;
        repeat (2) @(negedge clk);
        check("cfg_max_ok", config_error, 0);
        enable = 1'b0;
        @(negedge clk);
        ptos = 16'd1; enable = 1'b1; bus.data_valid = 1'b1; bus.data = 32'd7;
        repeat (3) @(negedge clk);
        check("cfg_p1_err", config_error, 1);
        check("cfg_p1_no_done", done, 0);
        enable = 1'b0;
        @(negedge clk);
        ptos = 16'd1025; enable = 1'b1;
        repeat (3) @(negedge clk);
        check("cfg_p1025_err", config_error, 1);
        enable = 1'b0; bus.data_valid = 1'b0;
        @(negedge clk);
        check("cfg_sticky_idle", config_error, 1);

        for (int i = 0; i < 6; i++) run_vec(tab[i]);

        // Abort in the final period: the in-flight sample must not surface
        ptos = 16'd4; ciclos = 16'd2; enable = 1'b1;
        @(negedge clk);
        for (int k = 0; k < 5; k++) begin
            bus.data_valid = 1'b1;
            bus.data = 32'(100 + k);
            @(negedge clk);
        end
        enable = 1'b0; bus.data_valid = 1'b0;
        repeat (4) @(negedge clk);
        check("abort_no_done", done, 0);
        check("abort_no_valid", bus.result_valid, 0);
        run_vec(abort_v);
        check("main_ovf_zero", overflow, 0);

        // Overflow instance: 0x7FFFFFFF summed twice wraps to -2
        @(negedge clk);
        o_ptos = 16'd2; o_ciclos = 16'd2; o_enable = 1'b1;
        @(negedge clk);
        for (int k = 0; k < 4; k++) begin
            obus.data_valid = 1'b1;
            obus.data = 32'h7FFF_FFFF;
            if (k == 3) check("ovf_not_yet", o_ovf, 0);
            @(negedge clk);
        end
        obus.data_valid = 1'b0;
        check("ovf_first_valid", obus.result_valid, 1);
        check("ovf_first_value", obus.result, 64'hFFFF_FFFE);
        check("ovf_first_index", obus.result_index, 0);
        check("ovf_flag", o_ovf, OVF_EXP);
        @(negedge clk);
        check("ovf_second_index", obus.result_index, 1);
        check("ovf_done", o_done, 1);
        @(negedge clk);
        check("ovf_sticky", o_ovf, OVF_EXP);

        // Asynchronous reset mid-cycle clears held outputs at once
        #2 reset_n = 1'b0;
        #1;
        check("arst_done", o_done, 0);
        check("arst_result", obus.result, 0);
        check("arst_ovf", o_ovf, 0);
        o_enable = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/coherent_averager.md
# coherent_averager

Streaming coherent (synchronous) averager that sits directly downstream of the data acquisition stage. It consumes one sample stream (simulated, high-speed ADC or ADC 2308), already brought into this block's clock domain, together with its `data_valid` strobe. It accumulates `ciclos` periods of `ptos_x_ciclo` samples point-by-point in an internal RAM. After the last period it emits one accumulated sum per point, so the next stage can divide or further process the averaged waveform.

## Interface
Parameters:
- `DATA_W`, default 32: input sample width, signed two's complement.
- `ACC_W`, default 48: accumulator/result width, signed; must be ≥ `DATA_W`.
- `ADDR_W`, default 10: RAM address width; MAX_PTS = 2^ADDR_W.

Ports:
- `clock` in 1: single clock; all logic is rising-edge.
- `reset_n` in 1: reset, asynchronous and active-low.
- `enable` in 1: level; high = run, low = abort/idle.
- `ptos_x_ciclo` in 16: points per period; valid range 2..MAX_PTS.
- `ciclos` in 16: periods to accumulate; 0 is treated as 1.
- `data_valid` in 1: sample strobe.
- `data` in DATA_W: signed sample.
- `result_valid` out 1: one-cycle strobe per emitted point.
- `result` out ACC_W: signed accumulated sum.
- `result_index` out 16: point index of `result`, 0..ptos_x_ciclo-1.
- `done` out 1: all points emitted; held until `enable` falls.
- `config_error` out 1: `ptos_x_ciclo` was out of range at start.
- `overflow` out 1: sticky accumulator overflow (see Configuration).

## Operation
- Reset: all outputs are 0, state is IDLE, and counters are 0. RAM contents are don't-care.
- States:
  - IDLE → ACCUM when `enable`=1 and `ptos_x_ciclo` is in range. `ptos_x_ciclo` and `ciclos` are latched at this transition and `config_error` is cleared.
  - If `ptos_x_ciclo` is out of range when `enable`=1, set `config_error` and stay in IDLE.
  - ACCUM → DONE after the last point of the last period has been emitted.
  - DONE → IDLE when `enable`=0.
  - Any state → IDLE on `enable`=0 at the next edge. In-flight pipeline data is discarded and no further `result_valid` is produced.
- Counters:
  - `idx` runs 0..P-1 and wraps to 0; `cyc` increments on each wrap. P = latched points, N = latched cycles (≥1).
- Per accepted sample (`data_valid`=1 in ACCUM):
  - The sum is sum = (cyc==0 ? 0 : RAM[idx]) + sign-extended data. Period 0 never reads the RAM, so no clearing pass is needed.
  - If cyc < N-1, write the sum back to RAM[idx].
  - If cyc == N-1, drive the sum on `result` with `result_index`=idx and `result_valid`=1. It is not written back.
- `data_valid` asserted in IDLE or DONE is ignored.
- Back-to-back valid samples are fully supported for any P ≥ 2. Writes complete before the same address is read again, so no forwarding is required.
- The block has no backpressure. Downstream must accept `result_valid` every cycle.

## Timing
- Two-stage pipeline:
  - Stage 1: RAM read issued, `data`/`idx`/flags registered.
  - Stage 2: add, then write or output register.
- `result_valid` rises exactly 2 cycles after the accepting `data_valid` edge.
- `done` rises in the same cycle as the final `result_valid`.
- `result`/`result_index` hold their last value when `result_valid`=0.
- The IDLE→ACCUM transition takes one cycle. A sample presented in the same cycle `enable` first rises is ignored; the first sample accepted is on the following cycle.
- Asynchronous reset mid-operation clears all outputs immediately. `done` is re-cleared on every new start.

## Configuration
- `COHERENT_AVG_OVERFLOW_EN` defined:
  - Stage 2 checks the signed ACC_W addition (operand signs equal, result sign differs).
  - On overflow, set `overflow` (sticky until reset or next IDLE→ACCUM). The sum still wraps.
- Not defined: `overflow` is tied to 0, no detection logic is built, and sums wrap silently.

## Test plan
- P=4, N=3, `data` = 10,20,30,40 repeated for 12 consecutive valid cycles → results 30,60,90,120 with indices 0..3. Each result appears 2 cycles after its sample, and `done`=1 with index 3.
- P=2, N=1, data −5, 7 back-to-back → results −5 (idx 0), 7 (idx 1), then `done`.
- P=8, N=2 with `data_valid` every third cycle, data = idx → results 0,2,…,14. No result before the second period.
- `enable` dropped after 5 samples of P=4, N=2; re-enabled with data=1 for 8 samples → results are 2,2,2,2. Stale RAM is ignored, and no result appeared during the abort.
- `ptos_x_ciclo`=1 or 1025 (ADDR_W=10) with `enable`=1 → `config_error`=1, no `result_valid`. Then P=4 → `config_error` clears on start.
- Macro defined, ACC_W=DATA_W=32, P=2, N=2, data=0x7FFFFFFF ×4 → `overflow`=1 at the first output. Without the macro → `overflow` stays 0.
